mc_main_control: RTL and testbench

- Multi-cycle main control FSM for the MIPS-subset datapath.
- Decodes the instruction opcode and sequences the datapath enables across several cycles per instruction.
- Drives the 2-bit alu_op consumed by the ALU control decoder, making it the encoder end of the ALUOp interface. It also handles a simple memory ready handshake.
- Sits between the instruction register opcode field and all datapath muxes and enables.

---
 rtl/mc_main_control_pkg.sv | 70 +++++++
 rtl/mc_ctrl_decode.sv | 86 ++++++++
 rtl/mc_main_control.sv | 97 +++++++++
 tb/tb_mc_main_control.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multi-cycle main control: opcodes, FSM states,
// datapath mux codes and the control bundle driven into the datapath.
package mc_main_control_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_ANDI  = 6'b001100;

  typedef enum logic [STATE_W-1:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MADDR  = 4'd3,
    ST_MREAD  = 4'd4,
    ST_MWRITE = 4'd5,
    ST_MWB    = 4'd6,
    ST_REXEC  = 4'd7,
    ST_RWB    = 4'd8,
    ST_IEXEC  = 4'd9,
    ST_IWB    = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

  // ALUOp codes, shared with the ALU control decoder.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_LOGIC = 2'b11;

  localparam logic [1:0] ALU_B_REG   = 2'b00;
  localparam logic [1:0] ALU_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_B_SHIMM = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_LW)   || (opc == OPC_SW)   ||
           (opc == OPC_BEQ)   || (opc == OPC_J)    || (opc == OPC_ADDI) ||
           (opc == OPC_ANDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore decode of the control FSM state into the datapath
// control bundle; only FETCH's IR/PC write looks at mem_ready.
module mc_ctrl_decode
  import mc_main_control_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode_q,
  input  logic             mem_ready,
  input  logic             illegal,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Branch target precompute; unknown opcodes flag here only.
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = ALU_B_SHIMM;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = illegal;
      end
      ST_MADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_MWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      ST_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      ST_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = (opcode_q == OPC_ANDI) ? ALU_OP_LOGIC : ALU_OP_ADD;
      end
      ST_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS-subset main control: state register, next-state logic and
// opcode latch; output decode lives in mc_ctrl_decode.
module mc_main_control
  import mc_main_control_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t           state;
  state_t           state_next;
  logic [OPC_W-1:0] opcode_q;
  logic             illegal;
  ctrl_t            ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_next;
  end

  // Opcode is only trusted while in DECODE; later states use this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  opcode_q <= '0;
    else if (state == ST_DECODE) opcode_q <= opcode;
  end

  assign illegal = !opc_is_legal(opcode);

  always_comb begin
    state_next = ST_FETCH;
    unique case (state)
      ST_RST:    state_next = ST_FETCH;
      ST_FETCH:  state_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if      (opcode == OPC_LW || opcode == OPC_SW)     state_next = ST_MADDR;
        else if (opcode == OPC_RTYPE)                      state_next = ST_REXEC;
        else if (opcode == OPC_BEQ)                        state_next = ST_BRANCH;
        else if (opcode == OPC_J)                          state_next = ST_JUMP;
        else if (opcode == OPC_ADDI || opcode == OPC_ANDI) state_next = ST_IEXEC;
        else                                               state_next = ST_FETCH;
      end
      ST_MADDR:  state_next = (opcode_q == OPC_LW) ? ST_MREAD : ST_MWRITE;
      ST_MREAD:  state_next = mem_ready ? ST_MWB : ST_MREAD;
      ST_MWRITE: state_next = mem_ready ? ST_FETCH : ST_MWRITE;
      ST_MWB:    state_next = ST_FETCH;
      ST_REXEC:  state_next = ST_RWB;
      ST_RWB:    state_next = ST_FETCH;
      ST_IEXEC:  state_next = ST_IWB;
      ST_IWB:    state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_JUMP:   state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .opcode_q  (opcode_q),
    .mem_ready (mem_ready),
    .illegal   (illegal),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_dbg     = STATE_W'(state);

endmodule

// File: tb/tb_mc_main_control.sv
// Directed, table-driven bench for mc_main_control: one row per clock cycle
// with hand-computed state and control outputs, plus an async-reset sequence.
module tb_mc_main_control;
  import mc_main_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  logic [16:0] act_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb[2], aop[2], psrc[2], ill}
  assign act_out = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

  localparam logic [16:0] O_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_FETCH = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_FWAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] O_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] O_MADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] O_MREAD = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] O_REXEC = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] O_RWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] O_IADD  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] O_IAND  = 17'b0_0_0_0_0_0_0_0_0_1_10_11_00_0;
  localparam logic [16:0] O_IWB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] O_BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] O_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

  localparam logic [3:0] S_RST = 4'd0,  S_FETCH = 4'd1,  S_DEC = 4'd2,  S_MADDR = 4'd3;
  localparam logic [3:0] S_MRD = 4'd4,  S_MWR = 4'd5,    S_MWB = 4'd6,  S_REXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8,  S_IEX = 4'd9,    S_IWB = 4'd10, S_BR = 4'd11;
  localparam logic [3:0] S_JMP = 4'd12;

  typedef struct {
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  state;
    logic [16:0] out;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [16:0] o);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.mem_ready = mr; v.state = st; v.out = o;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    // Reset, then R-type
    add(0, 6'b000000, 1, S_RST,   O_ZERO);
    add(1, 6'b000000, 1, S_RST,   O_ZERO);
    add(1, 6'b000000, 1, S_FETCH, O_FETCH);
    add(1, 6'b000000, 1, S_DEC,   O_DEC);
    add(1, 6'b111111, 1, S_REXEC, O_REXEC);
    add(1, 6'b111111, 1, S_RWB,   O_RWB);
    // LW with 3 wait cycles in MREAD; live opcode changed after DECODE
    add(1, 6'b100011, 1, S_FETCH, O_FETCH);
    add(1, 6'b100011, 1, S_DEC,   O_DEC);
    add(1, 6'b101011, 1, S_MADDR, O_MADDR);
    add(1, 6'b101011, 0, S_MRD,   O_MREAD);
    add(1, 6'b101011, 0, S_MRD,   O_MREAD);
    add(1, 6'b101011, 0, S_MRD,   O_MREAD);
    add(1, 6'b101011, 1, S_MRD,   O_MREAD);
    add(1, 6'b101011, 1, S_MWB,   O_MWB);
    // BEQ
    add(1, 6'b000100, 1, S_FETCH, O_FETCH);
    add(1, 6'b000100, 1, S_DEC,   O_DEC);
    add(1, 6'b000100, 1, S_BR,    O_BR);
    // ANDI (live opcode switched to ADDI in IEXEC must not matter)
    add(1, 6'b001100, 1, S_FETCH, O_FETCH);
    add(1, 6'b001100, 1, S_DEC,   O_DEC);
    add(1, 6'b001000, 1, S_IEX,   O_IAND);
    add(1, 6'b001000, 1, S_IWB,   O_IWB);
    // ADDI
    add(1, 6'b001000, 1, S_FETCH, O_FETCH);
    add(1, 6'b001000, 1, S_DEC,   O_DEC);
    add(1, 6'b001100, 1, S_IEX,   O_IADD);
    add(1, 6'b001100, 1, S_IWB,   O_IWB);
    // Illegal
    add(1, 6'b111111, 1, S_FETCH, O_FETCH);
    add(1, 6'b111111, 1, S_DEC,   O_ILL);
    // SW with one FETCH stall
    add(1, 6'b101011, 0, S_FETCH, O_FWAIT);
    add(1, 6'b101011, 1, S_FETCH, O_FETCH);
    add(1, 6'b101011, 1, S_DEC,   O_DEC);
    add(1, 6'b100011, 1, S_MADDR, O_MADDR);
    add(1, 6'b100011, 1, S_MWR,   O_MWR);
    // J
    add(1, 6'b000010, 1, S_FETCH, O_FETCH);
    add(1, 6'b000010, 1, S_DEC,   O_DEC);
    add(1, 6'b000010, 1, S_JMP,   O_JMP);
    // SW stalling in MWRITE, interrupted by reset below
    add(1, 6'b101011, 1, S_FETCH, O_FETCH);
    add(1, 6'b101011, 1, S_DEC,   O_DEC);
    add(1, 6'b101011, 1, S_MADDR, O_MADDR);
    add(1, 6'b101011, 0, S_MWR,   O_MWR);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n;
      opcode = vq[i].opcode;
      mem_ready = vq[i].mem_ready;
      #1;
      check($sformatf("state[%0d]", i), 32'(state_dbg), 32'(vq[i].state));
      check($sformatf("out[%0d]", i), 32'(act_out), 32'(vq[i].out));
      check($sformatf("rdwr_excl[%0d]", i), 32'(mem_read & mem_write), 32'd0);
    end

    // Still waiting in MWRITE; reset must clear outputs without a clock edge
    @(posedge clk);
    #2;
    check("mwrite_hold_state", 32'(state_dbg), 32'(S_MWR));
    check("mwrite_hold_mw", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mw", 32'(mem_write), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'(S_RST));
    check("async_rst_out", 32'(act_out), 32'(O_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("post_rst_state", 32'(state_dbg), 32'(S_RST));
    check("post_rst_out", 32'(act_out), 32'(O_ZERO));
    @(negedge clk);
    #1;
    check("post_rst_fetch", 32'(state_dbg), 32'(S_FETCH));
    check("post_rst_fetch_out", 32'(act_out), 32'(O_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
